// File: rtl/bcd_conv_scheduler.sv
// Round-robin scheduler sharing one bin2bcd converter among N_REQ requesters.
// A watchdog aborts a service when the converter never returns done.
//  state | meaning
//  IDLE  | no service; arbitrate when converter is ready
//  ISSUE | one-cycle start pulse to the converter
//  BUSY  | waiting for conv_done, watchdog counting
//  RESP  | one-cycle response to the served requester
module bcd_conv_scheduler #(
    parameter int N_REQ   = 3,
    parameter int BIN_W   = 14,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*BIN_W-1:0] bin_in,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic                   rsp_err,
    output logic [15:0]            bcd_out,
    output logic                   conv_start,
    output logic [BIN_W-1:0]       conv_bin,
    input  logic                   conv_ready,
    input  logic                   conv_done,
    input  logic [15:0]            conv_bcd
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] IDX_LAST = PTR_W'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

    state_t           state, state_nxt;
    logic [PTR_W-1:0] rr_ptr, idx, pick, cand_p;
    logic             found;
    logic [WD_W-1:0]  wdog;
    logic             err;
    logic [N_REQ-1:0] idx_onehot;
    int               cand;

    // First set request at or after rr_ptr, wrapping around.
    always_comb begin
        found  = 1'b0;
        pick   = '0;
        cand   = 0;
        cand_p = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_p = PTR_W'(cand);
            if (!found && req[cand_p]) begin
                found = 1'b1;
                pick  = cand_p;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (conv_ready && found) state_nxt = ISSUE;
            ISSUE:   state_nxt = BUSY;
            BUSY:    if (conv_done || (wdog == WD_LAST)) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            idx      <= '0;
            wdog     <= '0;
            err      <= 1'b0;
            bcd_out  <= '0;
            conv_bin <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (conv_ready && found) begin
                        idx      <= pick;
                        conv_bin <= bin_in[pick*BIN_W +: BIN_W];
                    end
                end
                ISSUE: wdog <= '0;
                BUSY: begin
                    // done wins over a watchdog expiry in the same cycle
                    if (conv_done) begin
                        bcd_out <= conv_bcd;
                        err     <= 1'b0;
                    end else if (wdog == WD_LAST) begin
                        err <= 1'b1;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                RESP: rr_ptr <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                default: ;
            endcase
        end
    end

    assign idx_onehot = N_REQ'(1) << idx;
    assign conv_start = (state == ISSUE);
    assign grant      = (state != IDLE) ? idx_onehot : '0;
    assign rsp_valid  = (state == RESP) ? idx_onehot : '0;
    assign rsp_err    = (state == RESP) && err;

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Bench for bcd_conv_scheduler: converter model, queue scoreboard, and a
// round-robin reference model that predicts service order, results and latency.
module tb_bcd_conv_scheduler;
    localparam int N  = 3;
    localparam int W  = 14;
    localparam int TO = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*W-1:0]   bin_in;
    logic [N-1:0]     grant, rsp_valid;
    logic             rsp_err;
    logic [15:0]      bcd_out;
    logic             conv_start;
    logic [W-1:0]     conv_bin;
    logic             conv_ready;
    logic             conv_done;
    logic [15:0]      conv_bcd;

    logic [W-1:0]     tb_bin [N];

    bcd_conv_scheduler #(.N_REQ(N), .BIN_W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .bin_in(bin_in), .grant(grant),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .bcd_out(bcd_out),
        .conv_start(conv_start), .conv_bin(conv_bin), .conv_ready(conv_ready),
        .conv_done(conv_done), .conv_bcd(conv_bcd)
    );

    always #5 clk = ~clk;

    always_comb begin
        bin_in = '0;
        for (int i = 0; i < N; i++) bin_in[i*W +: W] = tb_bin[i];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at cycle %0d", name, act, req_v, cyc);
        end
    endtask

    function automatic logic [15:0] to_bcd(int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Converter: done_tick conv_lat cycles after start, ready = ~busy.
    int       conv_lat  = 10;
    bit       conv_hang = 1'b0;
    bit       force_nr  = 1'b0;
    bit       cbusy     = 1'b0;
    int       ccnt      = 0;
    logic [W-1:0] cbin  = '0;
    assign conv_ready = ~cbusy & ~force_nr;

    initial begin
        conv_done = 1'b0;
        conv_bcd  = '0;
        forever begin
            @(posedge clk); #1;
            conv_done = 1'b0;
            if (cbusy) begin
                ccnt--;
                if (ccnt == 0) begin
                    cbusy = 1'b0;
                    if (!conv_hang) begin
                        conv_done = 1'b1;
                        conv_bcd  = to_bcd(int'(cbin));
                    end
                end
            end
            @(negedge clk);
            if (conv_start) begin
                cbusy = 1'b1;
                ccnt  = conv_hang ? 3 : conv_lat;
                cbin  = conv_bin;
            end
        end
    end

    typedef struct {
        int           idx;
        bit           err;
        logic [15:0]  bcd;
        int           lat;
        logic [W-1:0] opnd;
    } exp_t;
    exp_t sb[$];

    int          m_ptr  = 0;
    logic [15:0] m_last = '0;

    function automatic int arb(logic [N-1:0] m, int p);
        for (int k = 0; k < N; k++) if (m[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic expect_service(int i, bit hang);
        exp_t e;
        e.idx  = i;
        e.err  = hang;
        e.opnd = tb_bin[i];
        e.lat  = hang ? TO + 1 : conv_lat + 1;
        if (hang) begin
            e.bcd = m_last;
        end else begin
            e.bcd  = to_bcd(int'(tb_bin[i]));
            m_last = e.bcd;
        end
        sb.push_back(e);
        m_ptr = (i + 1) % N;
    endtask

    // Monitor: pops the scoreboard whenever a response is presented.
    int start_cyc = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) continue;
            if (conv_start) start_cyc = cyc;
            chk("grant_onehot", int'($countones(grant) <= 1), 1);
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rsp_valid=%b required none", rsp_valid);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_idx", int'(rsp_valid), 1 << e.idx);
                    chk("rsp_err", int'(rsp_err), int'(e.err));
                    chk("bcd_out", int'(bcd_out), int'(e.bcd));
                    chk("latency", cyc - start_cyc, e.lat);
                    chk("conv_bin_held", int'(conv_bin), int'(e.opnd));
                    chk("grant_in_resp", int'(grant), 1 << e.idx);
                end
            end
        end
    end

    task automatic wait_rsp(output int idx);
        idx = -1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                for (int i = 0; i < N; i++) if (rsp_valid[i]) idx = i;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL rsp_timeout: got no rsp_valid in 300 cycles, required one");
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        req = '0;
        sb.delete();
        m_ptr  = 0;
        m_last = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // All requests in m raised together, each dropped on its own response.
    task automatic phase(logic [N-1:0] m);
        logic [N-1:0] mm;
        int i, n;
        mm = m;
        n  = 0;
        while (mm != '0) begin
            i = arb(mm, m_ptr);
            expect_service(i, 1'b0);
            mm[i] = 1'b0;
            n++;
        end
        @(negedge clk);
        req = m;
        repeat (n) begin
            wait_rsp(i);
            if (i >= 0) req[i] = 1'b0;
        end
    endtask

    task automatic rand_bins();
        for (int k = 0; k < N; k++) tb_bin[k] = W'($urandom_range(0, 9999));
    endtask

    initial begin
        int i;
        logic [N-1:0] mm;
        bit ok;
        logic [W-1:0] v;

        rst = 1'b1;
        req = '0;
        for (int k = 0; k < N; k++) tb_bin[k] = '0;
        #1;
        chk("rst_grant", int'(grant), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_err", int'(rsp_err), 0);
        chk("rst_conv_start", int'(conv_start), 0);
        chk("rst_bcd_out", int'(bcd_out), 0);
        chk("rst_conv_bin", int'(conv_bin), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // single request, 1234
        conv_lat  = 10;
        tb_bin[0] = W'(1234);
        phase(3'b001);

        // all three together, twice, from a fresh pointer
        do_reset();
        rand_bins();
        conv_lat = $urandom_range(1, 40);
        phase(3'b111);
        rand_bins();
        phase(3'b111);

        // req[1], req[2] held; req[0] raised after the first response
        do_reset();
        rand_bins();
        conv_lat = $urandom_range(2, 20);
        mm = 3'b110;
        for (int s = 0; s < 5; s++) begin
            i = arb(mm, m_ptr);
            expect_service(i, 1'b0);
            if (s == 0) mm[0] = 1'b1;
            if (i == 0) mm[0] = 1'b0;
        end
        @(negedge clk);
        req = 3'b110;
        for (int s = 0; s < 5; s++) begin
            wait_rsp(i);
            if (s == 0) req[0] = 1'b1;
            if (i == 0) req[0] = 1'b0;
        end
        req = '0;

        // watchdog abort, then a normal service
        rand_bins();
        conv_hang = 1'b1;
        i = $urandom_range(0, N - 1);
        expect_service(i, 1'b1);
        @(negedge clk);
        req[i] = 1'b1;
        wait_rsp(i);
        if (i >= 0) req[i] = 1'b0;
        conv_hang = 1'b0;
        conv_lat  = $urandom_range(1, 40);
        phase(N'(1) << $urandom_range(0, N - 1));

        // converter not ready; operand changed after grant
        conv_lat  = 8;
        v         = W'($urandom_range(0, 9999));
        tb_bin[0] = v;
        @(negedge clk);
        force_nr = 1'b1;
        req      = 3'b001;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("nr_no_grant", int'(grant), 0);
            chk("nr_no_start", int'(conv_start), 0);
        end
        expect_service(0, 1'b0);
        force_nr = 1'b0;
        @(negedge clk);
        chk("grant_after_ready", int'(grant), 1);
        tb_bin[0] = v ^ W'(14'h155);
        wait_rsp(i);
        req = '0;

        // random rounds
        repeat (8) begin
            rand_bins();
            conv_lat = $urandom_range(1, 40);
            phase(N'($urandom_range(1, (1 << N) - 1)));
        end

        // reset while BUSY; late conv_done must be ignored, pointer back to 0
        do_reset();
        rand_bins();
        conv_lat = $urandom_range(1, 20);
        phase(3'b010);
        conv_lat = 30;
        @(negedge clk);
        req = 3'b100;
        ok  = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            ok = conv_start;
        end
        chk("t6_start_seen", int'(ok), 1);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        req = '0;
        sb.delete();
        m_ptr  = 0;
        m_last = '0;
        #1;
        chk("async_rst_grant", int'(grant), 0);
        chk("async_rst_start", int'(conv_start), 0);
        chk("async_rst_rsp", int'(rsp_valid), 0);
        chk("async_rst_bcd", int'(bcd_out), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("late_done_grant", int'(grant), 0);
        chk("late_done_bcd", int'(bcd_out), 0);
        rand_bins();
        conv_lat = $urandom_range(1, 20);
        phase(3'b101);

        for (int c = 0; c < 200 && sb.size() != 0; c++) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "global timeout");
    end

endmodule
